// File: rtl/grayscale.sv
// RGB888 -> 8-bit gray, two-stage stalled pipeline between FWFT FIFOs, with frame position tracking.
// Define GRAYSCALE_WEIGHTED_EN for BT.601-style weights (77,150,29)/256 instead of (R+G+B)*171/512.
module grayscale #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [7:0]  out_din,
  output logic        frame_done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

`ifdef GRAYSCALE_WEIGHTED_EN
  localparam int SW = 16;
`else
  localparam int SW = 10;
`endif

  logic [2:1]    vld_pipe;
  logic          en;
  logic [7:0]    r, g, b;
  logic [SW-1:0] sum, sum_nxt;
  logic [7:0]    gray, gray_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign en        = ~(vld_pipe[2] & out_full);
  // Never pop while reset is held, so no pixel is lost to a discarded pipeline.
  assign in_rd_en  = ~in_empty & en & ~reset;
  assign out_wr_en = vld_pipe[2] & ~out_full;
  assign out_din   = gray;

  assign r = in_dout[23:16];
  assign g = in_dout[15:8];
  assign b = in_dout[7:0];

`ifdef GRAYSCALE_WEIGHTED_EN
  // Weights sum to 256, so white lands exactly on 255 after dropping the low byte.
  assign sum_nxt  = 16'(r) * 16'd77 + 16'(g) * 16'd150 + 16'(b) * 16'd29;
  assign gray_nxt = 8'(sum >> 8);
`else
  logic [17:0] prod;
  // 171/512 ~= 1/3; max 765*171 fits in 17 bits.
  assign sum_nxt  = 10'(r) + 10'(g) + 10'(b);
  assign prod     = 18'(sum) * 18'd171;
  assign gray_nxt = 8'(prod >> 9);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      sum      <= '0;
      gray     <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[1], in_rd_en};
      if (in_rd_en)    sum  <= sum_nxt;
      if (vld_pipe[1]) gray <= gray_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_wr_en) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y == Y_LAST) begin
            y          <= '0;
            frame_done <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grayscale.sv
// Scoreboard bench for grayscale: driver pushes expected gray on each pop, monitor pops on each write.
module tb_grayscale;

  localparam int W = 4;
  localparam int H = 2;
  localparam int FRAME = W * H;
`ifdef GRAYSCALE_WEIGHTED_EN
  localparam logic [7:0] EXP3 = 8'd54;
`else
  localparam logic [7:0] EXP3 = 8'd60;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_rd_en;
  logic        in_empty;
  logic [23:0] in_dout;
  logic        out_wr_en;
  logic        out_full;
  logic [7:0]  out_din;
  logic        frame_done;

  grayscale #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .frame_done(frame_done)
  );

  initial forever #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nwr = 0;
  int npop = 0;
  int nfd = 0;
  int fpos = 0;
  bit exp_fd = 0;
  logic [23:0] stim[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  int          got_cyc[$];
  int          pop_cyc[$];

  initial forever @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [23:0] p);
    int s;
`ifdef GRAYSCALE_WEIGHTED_EN
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(s >> 8);
`else
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return 8'((s * 171) >> 9);
`endif
  endfunction

  // One clock: drive inputs just after the edge, observe the pop decision at the negedge.
  task automatic cycle(input bit empty_req, input bit full);
    @(posedge clock); #1;
    out_full = full;
    in_empty = empty_req || (stim.size() == 0);
    in_dout  = (stim.size() != 0) ? stim[0] : 24'h0;
    @(negedge clock);
    if (in_rd_en) begin
      exp_q.push_back(model(stim[0]));
      void'(stim.pop_front());
      pop_cyc.push_back(cyc);
      npop++;
    end
  endtask

  task automatic feed();
    for (int i = 0; i < 300 && stim.size() != 0; i++) cycle(1'b0, 1'b0);
    check("feed_done", stim.size(), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle(1'b1, 1'b0);
    check("drain_done", exp_q.size(), 0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
  endtask

  // Monitor: scoreboard compare and frame_done position model.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      fpos   = 0;
      exp_fd = 0;
    end else begin
      check("frame_done", frame_done, exp_fd);
      if (frame_done) nfd++;
      if (out_wr_en) begin
        check("wr_while_full", out_full, 0);
        check("out_din_known", $isunknown(out_din), 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %0h expected none", out_din);
        end else begin
          check("pixel", out_din, exp_q.pop_front());
        end
        got.push_back(out_din);
        got_cyc.push_back(cyc);
        nwr++;
      end
      exp_fd = out_wr_en && (fpos == FRAME - 1);
      if (out_wr_en) fpos = (fpos == FRAME - 1) ? 0 : fpos + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, nfd0;
    logic [7:0] held;
    reset = 1'b1; in_empty = 1'b0; in_dout = 24'h123456; out_full = 1'b0;
    #2;
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_out_din", out_din, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_rd_en", in_rd_en, 0);
    in_empty = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Directed values and latency
    got.delete(); got_cyc.delete(); pop_cyc.delete();
    stim.push_back(24'hFFFFFF); stim.push_back(24'h000000); stim.push_back({8'd30, 8'd60, 8'd90});
    feed(); drain();
    check("t1_count", got.size(), 3);
    if (got.size() >= 3 && pop_cyc.size() >= 1) begin
      check("t1_white", got[0], 255);
      check("t1_black", got[1], 0);
      check("t1_mix", got[2], EXP3);
      check("t1_latency", got_cyc[0] - pop_cyc[0], 2);
      check("t1_back_to_back", got_cyc[2] - got_cyc[0], 2);
    end

    // Backpressure for 5 cycles with a full pipeline
    n0 = nwr;
    for (int i = 0; i < 10; i++) stim.push_back(24'h030507 * (i + 1));
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    held = out_din;
    check("stall_wr", out_wr_en, 0);
    check("stall_rd", in_rd_en, 0);
    repeat (4) begin
      cycle(1'b0, 1'b1);
      check("stall_wr", out_wr_en, 0);
      check("stall_rd", in_rd_en, 0);
      check("stall_hold", out_din, held);
    end
    feed(); drain();
    check("stall_count", nwr - n0, 10);

    // Bubbles from an alternating empty input
    n0 = nwr;
    for (int i = 0; i < 8; i++) stim.push_back({8'(i * 31), 8'(200 - i * 7), 8'(i * 13 + 5)});
    for (int i = 0; i < 40 && stim.size() != 0; i++) cycle(i[0], 1'b0);
    drain();
    check("bubble_count", nwr - n0, 8);

    // Reset mid-frame with pixels in flight, then two clean frames
    n0 = nwr;
    for (int i = 0; i < 8; i++) stim.push_back(24'h102030 + 24'(i));
    for (int i = 0; i < 20 && (nwr - n0) < 3; i++) cycle(1'b0, 1'b0);
    check("pre_reset_writes", nwr - n0, 3);
    @(posedge clock); #1;
    reset = 1'b1; in_empty = 1'b1;
    #1 check("reset_wr_en", out_wr_en, 0);
    exp_q.delete(); stim.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) cycle(1'b1, 1'b0);
    n0 = nwr; nfd0 = nfd;
    for (int i = 0; i < 2 * FRAME; i++) stim.push_back({8'(i * 9), 8'(i * 5), 8'(255 - i)});
    feed(); drain();
    check("frame_writes", nwr - n0, 2 * FRAME);
    check("frame_pulses", nfd - nfd0, 2);

    // Random pixels with random empty/full
    n0 = nwr;
    for (int i = 0; i < 100; i++) stim.push_back(24'($urandom));
    for (int i = 0; i < 600 && stim.size() != 0; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    feed(); drain();
    check("random_count", nwr - n0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
